oneshot_arbiter: RTL
====================

Name: oneshot_arbiter

Overview:
Shares one down-counter pulse timer among NUM_REQ active-low trigger sources, such as the hit, wall and score sound one-shots.
- Each falling trigger edge becomes a latched request.
- A fixed-priority scheduler grants one request at a time and drives OUT high for that channel's programmed pulse length.
- Sits between the game-logic trigger nets and the sound mixer, replacing per-channel oneshot_555 instances.

Parameters:
NUM_REQ, 3, number of trigger channels; index 0 has the highest priority.
BIT_WIDTH, 16, counter width.
COUNTS, '{4,6,8}, unpacked array [NUM_REQ] of BIT_WIDTH values; pulse length in CLK cycles per channel; 0 = channel disabled.
GAP, 1, forced OUT-low cycles between consecutive pulses (0 allowed).

Ports:
CLK  in  1  system clock, single clock domain.
RESET  in  1  asynchronous, active-high reset.
TRG_N  in  NUM_REQ  active-low triggers; synchronous to CLK.
OUT  out  1  pulse output, high while a grant is active.
GRANT  out  NUM_REQ  one-hot owner of the current pulse; all-zero when not ACTIVE.
PENDING  out  NUM_REQ  latched, not-yet-served requests.
BUSY  out  1  high in ACTIVE or GAP.

Behaviour:
- Reset (asynchronous): OUT=0, GRANT=0, PENDING=0, BUSY=0, state=IDLE, counter=0, trg_q=all 1s, so no false edge is seen on release.
- Edge detect: fall[i] = trg_q[i] & ~TRG_N[i]. trg_q <= TRG_N every cycle. A held-low trigger yields exactly one request.
- Request latching: PENDING[i] sets on the edge where fall[i]=1 and COUNTS[i]!=0. Disabled channels never set PENDING.
- PENDING[i] clears on the edge that grants channel i.
- A fall on channel i is dropped, not latched, when:
  - the grant is moving to channel i on that same edge, or
  - channel i is the current owner in ACTIVE.
  This gives non-retriggerable 555 semantics.
- FSM states: IDLE, ACTIVE, GAP.
- IDLE: if PENDING!=0, on the next edge go to ACTIVE.
  - Grant the lowest index set in PENDING: GRANT=onehot, OUT=1, BUSY=1, counter=COUNTS[i]-1.
  - Latency: trigger sampled low at edge E0 gives PENDING at E0 and OUT=1 from E0+1.
- ACTIVE: counter decrements each cycle. On the edge where counter==0 leave ACTIVE:
  - OUT=0, GRANT=0.
  - Go to GAP with gap counter=GAP-1, or straight to IDLE-equivalent arbitration if GAP=0.
  - OUT is high for exactly COUNTS[i] cycles.
- GAP: OUT=0, BUSY=1, for GAP cycles, then IDLE. BUSY drops only if PENDING=0.
- GAP=0 back-to-back case: when PENDING!=0 at the end of ACTIVE, the next grant loads on the same edge.
  - OUT stays continuously high; GRANT changes owner.
- Simultaneous falls: all are latched and served in index order.
- Counter arithmetic: unsigned BIT_WIDTH, no wrap. COUNTS values must be < 2**BIT_WIDTH (elaboration assertion).
- Reset mid-pulse: immediate return to reset values; PENDING is lost.

Optional Feature:
Macro ONESHOT_ARB_PREEMPT_EN.
- Defined: in ACTIVE, if PENDING[j] is set with j < owner index, the next edge does all of the following:
  - reloads counter=COUNTS[j]-1;
  - moves GRANT to j and clears PENDING[j];
  - keeps OUT high with no gap;
  - discards the preempted channel's remaining time (it is not re-queued).
- Undefined: strictly non-preemptive; higher-priority requests wait in PENDING until ACTIVE and GAP complete.

Decomposition:
- Package oneshot_arb_pkg holds:
  - the state typedef, an enum {IDLE, ACTIVE, GAP};
  - a function returning the lowest-set-bit index / one-hot of a vector;
  - the default COUNTS constant.
- One sub-module, trigger_edge_detect: per-channel trg_q register plus the fall output, reset to 1.

Test Plan:
All scenarios use NUM_REQ=3, COUNTS='{4,6,8}, GAP=2, CLK period 100 ns.
1. Reset release with TRG_N=3'b111 -> OUT=0, GRANT=0, PENDING=0, BUSY=0; no request for 10 cycles.
2. TRG_N[1] low for 1 cycle -> PENDING=3'b010 at E0; from E0+1, OUT=1 for exactly 6 cycles with GRANT=3'b010; then 2 cycles BUSY=1 with OUT=0; then IDLE.
3. TRG_N[2] and TRG_N[0] fall on the same edge -> ch0 pulse 4 cycles, 2 gap cycles, then ch2 pulse 8 cycles; PENDING goes 101 -> 100 -> 000.
4. Retrigger TRG_N[1] at cycle 3 of its own pulse; also hold TRG_N[0] low 20 cycles -> no extra ch1 pulse; exactly one ch0 pulse.
5. With ONESHOT_ARB_PREEMPT_EN: ch2 active, ch0 falls at pulse cycle 3 -> OUT stays high, GRANT switches to 3'b001 for 4 cycles, ch2 not resumed. Without the macro: ch2 completes 8 cycles, gap 2, then ch0 for 4 cycles.
6. Assert RESET at cycle 2 of a ch1 pulse with ch2 pending -> all outputs 0 asynchronously; no pulse after release until a new falling edge.

Source files
------------

// File: rtl/oneshot_arb_pkg.sv
// Shared types and helpers for the one-shot pulse arbiter.
// Holds the FSM state type, the default pulse table and the priority pick function.
package oneshot_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_GAP
    } arb_state_t;

    localparam int MAX_REQ = 32;

    localparam int unsigned DEFAULT_COUNTS [3] = '{4, 6, 8};

    // Isolates the lowest set bit, which is the highest-priority request.
    function automatic logic [MAX_REQ-1:0] lowest_onehot(input logic [MAX_REQ-1:0] v);
        return v & (~v + MAX_REQ'(1));
    endfunction

endpackage

// File: rtl/oneshot_arbiter_trigger_edge_detect.sv
// Per-channel falling-edge detector for the active-low trigger nets.
// The history register resets high so releasing reset never looks like an edge.
module trigger_edge_detect
    import oneshot_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] trg_n,
    output logic [NUM_REQ-1:0] fall
);

    logic [NUM_REQ-1:0] trg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trg_q <= '1;
        end else begin
            trg_q <= trg_n;
        end
    end

    assign fall = trg_q & ~trg_n;

endmodule

// File: rtl/oneshot_arbiter.sv
// Shares one pulse down-counter among NUM_REQ trigger channels with fixed priority.
// Define ONESHOT_ARB_PREEMPT_EN to let a higher-priority request cut the current pulse short.
module oneshot_arbiter
    import oneshot_arb_pkg::*;
#(
    parameter int          NUM_REQ   = 3,
    parameter int          BIT_WIDTH = 16,
    parameter int unsigned COUNTS [NUM_REQ] = DEFAULT_COUNTS,
    parameter int unsigned GAP       = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_REQ-1:0] TRG_N,
    output logic               OUT,
    output logic [NUM_REQ-1:0] GRANT,
    output logic [NUM_REQ-1:0] PENDING,
    output logic               BUSY
);

    localparam logic [BIT_WIDTH-1:0] GAP_M1 = (GAP == 0) ? '0 : BIT_WIDTH'(GAP - 1);

    arb_state_t           state_q, state_d;
    logic [BIT_WIDTH-1:0] count_q, count_d, load_val;
    logic [BIT_WIDTH-1:0] count_m1 [NUM_REQ];
    logic [NUM_REQ-1:0]   fall, enabled, pick, clear, drop;
    logic [NUM_REQ-1:0]   pending_q, pending_d, grant_q, grant_d;
    logic                 preempt;

    trigger_edge_detect #(
        .NUM_REQ(NUM_REQ)
    ) u_edge (
        .clk  (CLK),
        .rst  (RESET),
        .trg_n(TRG_N),
        .fall (fall)
    );

    if (64'(GAP) >= (64'd1 << BIT_WIDTH)) begin : g_bad_gap
        $error("oneshot_arbiter: GAP does not fit in BIT_WIDTH");
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
        if (64'(COUNTS[i]) >= (64'd1 << BIT_WIDTH)) begin : g_bad_count
            $error("oneshot_arbiter: COUNTS entry does not fit in BIT_WIDTH");
        end
        assign enabled[i]  = (COUNTS[i] != 0);
        assign count_m1[i] = BIT_WIDTH'(COUNTS[i] - 1);
    end

    assign pick = NUM_REQ'(lowest_onehot(MAX_REQ'(pending_q)));

    always_comb begin
        load_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                load_val = count_m1[i];
            end
        end
    end

`ifdef ONESHOT_ARB_PREEMPT_EN
    // Any pending bit below the owner's index outranks it; grant_q is one-hot in ACTIVE.
    assign preempt = |(pending_q & (grant_q - NUM_REQ'(1)));
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        grant_d = grant_q;
        clear   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    state_d = ST_ACTIVE;
                    grant_d = pick;
                    count_d = load_val;
                    clear   = pick;
                end
            end
            ST_ACTIVE: begin
                if (preempt) begin
                    grant_d = pick;
                    count_d = load_val;
                    clear   = pick;
                end else if (count_q == '0) begin
                    grant_d = '0;
                    if (GAP != 0) begin
                        state_d = ST_GAP;
                        count_d = GAP_M1;
                    end else if (|pending_q) begin
                        // Back-to-back hand-over keeps OUT continuously high.
                        grant_d = pick;
                        count_d = load_val;
                        clear   = pick;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q - BIT_WIDTH'(1);
                end
            end
            ST_GAP: begin
                if (count_q == '0) begin
                    if (|pending_q) begin
                        state_d = ST_ACTIVE;
                        grant_d = pick;
                        count_d = load_val;
                        clear   = pick;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q - BIT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

    // Falls on the incoming or current owner are ignored: pulses are not retriggerable.
    assign drop      = clear | ((state_q == ST_ACTIVE) ? grant_q : '0);
    assign pending_d = (pending_q & ~clear) | (fall & enabled & ~drop);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            grant_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
        end
    end

    assign OUT     = (state_q == ST_ACTIVE);
    assign GRANT   = grant_q;
    assign PENDING = pending_q;
    assign BUSY    = (state_q != ST_IDLE);

endmodule
